// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and the PLL/reset consumers.
// The supervisor uses the master modport; the environment driving LOCK uses slave.
interface pll_lock_supervisor_if #(
    parameter int CNT_W = 8
);
    // No valid/ready handshake: locked is a level sampled every cycle through
    // the synchroniser, clear_cnt is a one-cycle pulse acted on at the next edge,
    // and ready is a level that stays high for as long as the PLL clocks are usable.
    logic             locked;
    logic             clear_cnt;
    logic             pll_rst;
    logic             sys_rst_n;
    logic             ready;
    logic [1:0]       state;
    logic [CNT_W-1:0] lost_cnt;
    logic [CNT_W-1:0] timeout_cnt;

    modport master (
        input  locked,
        input  clear_cnt,
        output pll_rst,
        output sys_rst_n,
        output ready,
        output state,
        output lost_cnt,
        output timeout_cnt
    );

    modport slave (
        output locked,
        output clear_cnt,
        input  pll_rst,
        input  sys_rst_n,
        input  ready,
        input  state,
        input  lost_cnt,
        input  timeout_cnt
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Resets the video PLL, qualifies its LOCK output and only then releases the
// downstream reset; lock loss and lock timeouts re-reset the PLL and are counted.
module pll_lock_supervisor #(
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 250000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pll_lock_supervisor_if.master        bus
);
    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int MAX_A   = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    state_t             state_q;
    state_t             state_d;
    logic [TMR_W-1:0]   timer_q;
    logic               lock_meta;
    logic               locked_s;
    logic               lost_inc;
    logic               timeout_inc;
    logic [CNT_W-1:0]   lost_q;
    logic [CNT_W-1:0]   timeout_q;
    logic               pll_rst_q;
    logic               sys_rst_n_q;
    logic               ready_q;

    // LOCK is asynchronous to clk; nothing else may look at bus.locked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= bus.locked;
            locked_s  <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_PLL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lost_inc    = 1'b0;
        timeout_inc = 1'b0;
        case (state_q)
            RESET_PLL: begin
                if (timer_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // A lock that arrives on the timeout cycle still counts as a lock.
                if (locked_s) begin
                    state_d = STABLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d     = RESET_PLL;
                    timeout_inc = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d  = RESET_PLL;
                    lost_inc = 1'b1;
                end
            end
            default: state_d = RESET_PLL;
        endcase
    end

    // Shared interval timer: restarts from zero whenever the state changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (state_d != state_q) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_q    <= '0;
            timeout_q <= '0;
        end else if (bus.clear_cnt) begin
            lost_q    <= '0;
            timeout_q <= '0;
        end else begin
            if (lost_inc && (lost_q != CNT_MAX)) begin
                lost_q <= lost_q + CNT_W'(1);
            end
            if (timeout_inc && (timeout_q != CNT_MAX)) begin
                timeout_q <= timeout_q + CNT_W'(1);
            end
        end
    end

    // Outputs are flops loaded from the next state so they track state_q exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            pll_rst_q   <= (state_d == RESET_PLL);
            sys_rst_n_q <= (state_d == RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_rst_n   = sys_rst_n_q;
    assign bus.ready       = ready_q;
    assign bus.state       = state_q;
    assign bus.lost_cnt    = lost_q;
    assign bus.timeout_cnt = timeout_q;

endmodule
